frame_tpg: RTL and testbench

Frame timing and test-pattern generator: the master end of the frame interface. It produces `frame_vsync`, `frame_hsync`, `frame_vs`, `frame_hs`, `frame_de` and `frame_data` for downstream frame-slave blocks (3DNR datapath, capture, write DMA). It is used as the bring-up source and as the bench stimulus for every frame consumer. Raster geometry is parameterised, and the pattern is selected at run time.

---
 rtl/frame_if.sv | 28 ++
 rtl/frame_tpg.sv | 155 +++++++++++++++
 tb/tb_frame_tpg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/frame_if.sv
// Frame bus carried from a frame master (timing/pattern source) to frame slaves.
// frame_de is the only qualifier: frame_data is meaningful exactly in cycles
// where frame_de=1, and there is no backpressure (slaves must accept every
// pixel). The sync/envelope signals are level timing markers. frame_done
// marks the last cycle of a frame. busy is high for every output cycle of a
// frame.
interface frame_if #(
  parameter int DW = 8
);
  logic          frame_vsync;
  logic          frame_hsync;
  logic          frame_vs;
  logic          frame_hs;
  logic          frame_de;
  logic [DW-1:0] frame_data;
  logic          frame_done;
  logic          busy;

  modport master (
    output frame_vsync, frame_hsync, frame_vs, frame_hs,
           frame_de, frame_data, frame_done, busy
  );

  modport slave (
    input frame_vsync, frame_hsync, frame_vs, frame_hs,
          frame_de, frame_data, frame_done, busy
  );
endinterface

// File: rtl/frame_tpg.sv
// Frame timing and test-pattern generator. Walks a raster of
// H_TOTAL x V_TOTAL pixel-clock slots and drives registered sync, envelope,
// data-enable and pattern outputs. The pattern select and constant are
// shadowed at each frame start, so changes take effect on frame boundaries.
module frame_tpg #(
  parameter int DW       = 8,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    pat_sel,
  input  logic [DW-1:0] pat_const,
  frame_if.master       fo,
  output logic          fsm_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // Region boundaries sized to the counters; all fit because every porch >= 1.
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_next;
  logic          load_shadow;
  logic          cnt_run;      // counters hold a live raster position
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    sh_sel;
  logic [DW-1:0] sh_const;
  logic          last_c, hs_c, vs_c, de_c, hsync_c, vsync_c;
  logic [DW-1:0] pat_c;

  assign fsm_state = state;

  assign last_c  = cnt_run && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign hs_c    = h_cnt < H_ACT;
  assign vs_c    = v_cnt < V_ACT;
  assign de_c    = hs_c && vs_c;
  assign hsync_c = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vsync_c = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Next state: start from IDLE on en; at the last slot continue or stop.
  always_comb begin
    state_next  = state;
    load_shadow = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next  = RUN;
          load_shadow = 1'b1;
        end
      end
      RUN: begin
        if (last_c) begin
          if (en) load_shadow = 1'b1;
          else    state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Pattern shadows, captured only at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_sel   <= '0;
      sh_const <= '0;
    end else if (load_shadow) begin
      sh_sel   <= pat_sel;
      sh_const <= pat_const;
    end
  end

  // Counters go live one cycle after entering RUN and stay live across
  // back-to-back frames; they come to rest at (0,0) via the natural wrap.
  always_ff @(posedge clk) begin
    if (rst) cnt_run <= 1'b0;
    else     cnt_run <= (state == RUN) && !(last_c && !en);
  end

  // Raster position: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (cnt_run) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Pattern from the current raster position and the shadowed select.
  always_comb begin
    pat_c = '0;
    case (sh_sel)
      2'd0:    pat_c = DW'(h_cnt);
      2'd1:    pat_c = DW'(v_cnt);
      2'd2:    pat_c = DW'(h_cnt) ^ DW'(v_cnt);
      default: pat_c = sh_const;
    endcase
  end

  // Output flops: one cycle behind the decode, all zero outside a live raster.
  always_ff @(posedge clk) begin
    if (rst || !cnt_run) begin
      fo.frame_vsync <= 1'b0;
      fo.frame_hsync <= 1'b0;
      fo.frame_vs    <= 1'b0;
      fo.frame_hs    <= 1'b0;
      fo.frame_de    <= 1'b0;
      fo.frame_data  <= '0;
      fo.frame_done  <= 1'b0;
      fo.busy        <= 1'b0;
    end else begin
      fo.frame_vsync <= vsync_c;
      fo.frame_hsync <= hsync_c;
      fo.frame_vs    <= vs_c;
      fo.frame_hs    <= hs_c;
      fo.frame_de    <= de_c;
      fo.frame_data  <= de_c ? pat_c : '0;
      fo.frame_done  <= last_c;
      fo.busy        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_tpg.sv
// Bench for frame_tpg on a small 8x6 raster. A reference model predicts whole
// frames at each frame-start opportunity and queues one stamped expectation
// per output cycle; a monitor checks every cycle against that queue.
module tb_frame_tpg;

  localparam int DW = 8;
  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FRAME = HT * VT;
  localparam int W = 7 + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    pat_sel;
  logic [DW-1:0] pat_const;
  logic          fsm_state;

  frame_if #(.DW(DW)) fif ();

  frame_tpg #(
    .DW(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel),
    .pat_const(pat_const), .fo(fif.master), .fsm_state(fsm_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  int           stamp_q[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           m_run = 1'b0;
  int           m_end = 0;

  // Expected output of one frame slot, from the raster rules.
  function automatic logic [W-1:0] slot_vec(int k, logic [1:0] sel, logic [DW-1:0] c);
    int x, y;
    logic vsync, hsync, vs, hs, de, done;
    logic [DW-1:0] d;
    x = k % HT;
    y = k / HT;
    hs    = (x < 4);
    vs    = (y < 3);
    de    = hs && vs;
    hsync = (x >= 5) && (x < 7);
    vsync = (y == 4);
    done  = (k == FRAME - 1);
    case (sel)
      2'd0:    d = DW'(x);
      2'd1:    d = DW'(y);
      2'd2:    d = DW'(x ^ y);
      default: d = c;
    endcase
    if (!de) d = '0;
    return {vsync, hsync, vs, hs, de, done, 1'b1, d};
  endfunction

  task automatic push_frame(int first, logic [1:0] sel, logic [DW-1:0] c);
    for (int k = 0; k < FRAME; k++) begin
      exp_q.push_back(slot_vec(k, sel, c));
      stamp_q.push_back(first + k);
    end
  endtask

  // Reference model: frames start when en is seen in idle (output two edges
  // later) or at the end of a frame (output from the very next edge).
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_run = 1'b0;
      exp_q.delete();
      stamp_q.delete();
    end else if (!m_run) begin
      if (en) begin
        push_frame(cyc + 2, pat_sel, pat_const);
        m_end = cyc + 2 + FRAME - 1;
        m_run = 1'b1;
      end
    end else if (cyc == m_end) begin
      if (en) begin
        push_frame(cyc + 1, pat_sel, pat_const);
        m_end = cyc + FRAME;
      end else begin
        m_run = 1'b0;
      end
    end
  end

  // Monitor: busy marks an output cycle; otherwise every output must be 0.
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    int st;
    act = {fif.frame_vsync, fif.frame_hsync, fif.frame_vs, fif.frame_hs,
           fif.frame_de, fif.frame_done, fif.busy, fif.frame_data};
    while (stamp_q.size() > 0 && stamp_q[0] < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_slot: stamp %0d not presented, now cycle %0d", stamp_q[0], cyc);
      void'(stamp_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (fif.busy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: cycle %0d got %h, required idle", cyc, act);
      end else begin
        e  = exp_q.pop_front();
        st = stamp_q.pop_front();
        if (act !== e || st != cyc) begin
          n_bad++;
          $display("FAIL frame_slot: cycle %0d got %h, required %h at cycle %0d", cyc, act, e, st);
        end
      end
    end else begin
      n_cmp++;
      if (act !== '0) begin
        n_bad++;
        $display("FAIL idle_outputs: cycle %0d got %h, required 0", cyc, act);
      end
    end
  end

  // Stimulus.
  initial begin
    rst = 1'b1; en = 1'b0; pat_sel = 2'd0; pat_const = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);            // idle, en low
    en = 1'b1;                              // two frames of pattern 0
    repeat (100) @(negedge clk);
    pat_sel = 2'd2;                          // picked up at next frame start
    repeat (60) @(negedge clk);
    pat_sel = 2'd3; pat_const = 8'hA5;      // mid-frame change
    repeat (90) @(negedge clk);
    en = 1'b0;                              // frame completes, then idle
    repeat (80) @(negedge clk);
    pat_sel = 2'd0;
    en = 1'b1;                              // reset in the middle of line 1
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) pat_sel = 2'($urandom_range(0, 3));
      pat_const = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
